mem_access_stage: RTL and testbench

//  Pipeline stage 4 (MEM), directly downstream of the stage-3 ALU. Takes the ALU result
//  as a load/store address, or passes it through for non-memory ops. Drives a
//  req/ack data-memory port with byte enables. Performs load sign/zero extension and

---
 rtl/mem_access_stage.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//   Pipeline stage 4 (MEM). Takes the stage-3 ALU result as a load/store byte
//   address, or passes it straight through for non-memory ops. Drives a req/ack
//   data-memory port with byte enables. Formats load data with sign or zero
//   extension and hands a registered result to writeback.
//
// Handshakes:
//   EX side     : an op transfers on a rising edge where ex_valid & ex_ready.
//                 ex_ready depends only on state and wb_ready.
//   Writeback   : a result transfers on a rising edge where wb_valid & wb_ready.
//                 While wb_valid=1 and wb_ready=0 every wb_* output holds.
//   Data memory : dmem_req rises with address/controls and holds them until
//                 the cycle dmem_ack is seen; dmem_rdata/dmem_err are sampled
//                 only in that cycle.
//
// Ports:
//   clk, reset_n                        clock, async active-low reset
//   ex_valid/ex_ready                   op handshake from EX
//   ex_alu_result, ex_store_data        address / passthrough value, store data
//   ex_mem_read, ex_mem_write           load / store (both set = load)
//   ex_funct3, ex_rd, ex_reg_write      access size/sign, destination, write en
//   dmem_req/we/addr/wdata/be           data-memory request
//   dmem_ack/rdata/err                  data-memory completion
//   wb_valid/ready, wb_data, wb_rd,     result to writeback
//   wb_reg_write, wb_exc, wb_exc_cause  (cause 00 none,01 misalign,10 bus,11 timeout)
//   dbg_state                           current FSM state (IDLE=0, BUS=1, HOLD=2)
// -----------------------------------------------------------------------------
module mem_access_stage #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_err,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        wb_exc,
  output logic [1:0]  wb_exc_cause,
  output logic [1:0]  dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;
  // Op context kept across the bus access
  logic             op_load;
  logic             op_rw;
  logic [1:0]       op_lane;
  logic [2:0]       op_funct3;

  // ---------------------------------------------------------------------------
  // Decode of the op presented by EX
  // ---------------------------------------------------------------------------
  logic        accept;
  logic        is_load;
  logic        is_store;
  logic        sz_b;
  logic        sz_h;
  logic        misaligned;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;

  assign ex_ready  = (state == IDLE) | ((state == HOLD) & wb_ready);
  assign accept    = ex_valid & ex_ready;
  assign dbg_state = state;

  // A load with mem_write also set is still a load.
  assign is_load  = ex_mem_read;
  assign is_store = ex_mem_write & ~ex_mem_read;

  // funct3[1:0]: 00 byte, 01 half, anything else is a word access.
  assign sz_b = (ex_funct3[1:0] == 2'b00);
  assign sz_h = (ex_funct3[1:0] == 2'b01);

  always_comb begin
    misaligned = 1'b0;
    be_n       = 4'b1111;
    wdata_n    = ex_store_data;
    if (sz_b) begin
      be_n    = 4'b0001 << ex_alu_result[1:0];
      wdata_n = {4{ex_store_data[7:0]}};
    end else if (sz_h) begin
      misaligned = ex_alu_result[0];
      be_n       = 4'b0011 << ex_alu_result[1:0];
      wdata_n    = {2{ex_store_data[15:0]}};
    end else begin
      misaligned = |ex_alu_result[1:0];
    end
  end

  // Move the addressed lane to the bottom and extend per funct3.
  function automatic logic [31:0] fmt_load(input logic [31:0] word,
                                           input logic [1:0]  lane,
                                           input logic [2:0]  f3);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (f3)
      3'b000:  fmt_load = {{24{sh[7]}}, sh[7:0]};
      3'b001:  fmt_load = {{16{sh[15]}}, sh[15:0]};
      3'b100:  fmt_load = {24'h0, sh[7:0]};
      3'b101:  fmt_load = {16'h0, sh[15:0]};
      default: fmt_load = word;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      tmo_cnt      <= '0;
      op_load      <= 1'b0;
      op_rw        <= 1'b0;
      op_lane      <= 2'b00;
      op_funct3    <= 3'b000;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_be      <= 4'b0000;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= 5'd0;
      wb_reg_write <= 1'b0;
      wb_exc       <= 1'b0;
      wb_exc_cause <= 2'b00;
    end else begin
      case (state)
        BUS: begin
          if (dmem_ack) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            wb_valid     <= 1'b1;
            state        <= HOLD;
            wb_exc       <= dmem_err;
            wb_exc_cause <= dmem_err ? 2'b10 : 2'b00;
            wb_reg_write <= ~dmem_err & op_load & op_rw;
            wb_data      <= (op_load & ~dmem_err) ?
                            fmt_load(dmem_rdata, op_lane, op_funct3) :
                            {dmem_addr[31:2], op_lane};
          end else if (tmo_cnt == CNT_LAST) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            wb_valid     <= 1'b1;
            state        <= HOLD;
            wb_exc       <= 1'b1;
            wb_exc_cause <= 2'b11;
            wb_reg_write <= 1'b0;
            wb_data      <= {dmem_addr[31:2], op_lane};
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        default: begin  // IDLE and HOLD share the accept path
          if (accept) begin
            wb_rd <= ex_rd;
            if (!(is_load | is_store)) begin
              wb_valid     <= 1'b1;
              wb_data      <= ex_alu_result;
              wb_reg_write <= ex_reg_write & (ex_rd != 5'd0);
              wb_exc       <= 1'b0;
              wb_exc_cause <= 2'b00;
              state        <= HOLD;
            end else if (misaligned) begin
              wb_valid     <= 1'b1;
              wb_data      <= ex_alu_result;
              wb_reg_write <= 1'b0;
              wb_exc       <= 1'b1;
              wb_exc_cause <= 2'b01;
              state        <= HOLD;
            end else begin
              wb_valid     <= 1'b0;
              wb_reg_write <= 1'b0;
              wb_exc       <= 1'b0;
              wb_exc_cause <= 2'b00;
              dmem_req     <= 1'b1;
              dmem_we      <= is_store;
              dmem_addr    <= {ex_alu_result[31:2], 2'b00};
              dmem_be      <= be_n;
              dmem_wdata   <= wdata_n;
              tmo_cnt      <= '0;
              op_load      <= is_load;
              op_rw        <= ex_reg_write & (ex_rd != 5'd0);
              op_lane      <= ex_alu_result[1:0];
              op_funct3    <= ex_funct3;
              state        <= BUS;
            end
          end else if ((state == HOLD) && wb_ready) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_exc       <= 1'b0;
            wb_exc_cause <= 2'b00;
            state        <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
`timescale 1ns/1ps
module tb_mem_access_stage;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic reset_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        ex_valid, ex_ready;
  logic [31:0] ex_alu_result, ex_store_data;
  logic        ex_mem_read, ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        dmem_err;
  logic        wb_valid, wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write, wb_exc;
  logic [1:0]  wb_exc_cause;
  logic [1:0]  dbg_state;

  mem_access_stage #(.TIMEOUT_CYC(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .dmem_err(dmem_err),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_exc(wb_exc),
    .wb_exc_cause(wb_exc_cause), .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // wb entry : {chk_data, exc, cause[1:0], reg_write, rd[4:0], data[31:0]}
  // bus entry: {we, addr[31:0], be[3:0], wdata[31:0]}
  // ---------------------------------------------------------------------------
  logic [41:0] exp_q[$];
  logic [68:0] bus_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [41:0] mk_wb(input logic chk, input logic exc, input logic [1:0] cause,
                                        input logic rw, input logic [4:0] rd, input logic [31:0] data);
    return {chk, exc, cause, rw, rd, data};
  endfunction

  // Writeback monitor: while a result is presented it must match the head
  // entry every cycle (covers hold stability); pop on transfer.
  initial begin
    logic [41:0] e;
    forever begin
      @(negedge clk);
      if (reset_n && wb_valid) begin
        if (exp_q.size() == 0) begin
          fail_now("wb_unexpected_result");
        end else begin
          e = exp_q[0];
          check("wb_exc", 64'(wb_exc), 64'(e[40]));
          check("wb_exc_cause", 64'(wb_exc_cause), 64'(e[39:38]));
          check("wb_reg_write", 64'(wb_reg_write), 64'(e[37]));
          check("wb_rd", 64'(wb_rd), 64'(e[36:32]));
          if (e[41]) check("wb_data", 64'(wb_data), 64'(e[31:0]));
          if (wb_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Data-memory responder
  // ---------------------------------------------------------------------------
  int          resp_lat       = 0;
  logic        resp_err       = 1'b0;
  logic        resp_noack     = 1'b0;
  logic [31:0] resp_rdata     = 32'h0;
  int          exp_req_cycles = 0;

  initial begin
    logic [68:0] cur;
    bit          in_req;
    int          wait_cnt;
    in_req   = 0;
    wait_cnt = 0;
    cur      = '0;
    dmem_ack = 1'b0; dmem_err = 1'b0; dmem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      dmem_ack = 1'b0;
      dmem_err = 1'b0;
      if (dmem_req) begin
        if (!in_req) begin
          in_req   = 1;
          wait_cnt = 0;
          if (bus_q.size() == 0) begin
            fail_now("bus_unexpected_req");
            cur = {dmem_we, dmem_addr, dmem_be, dmem_wdata};
          end else begin
            cur = bus_q.pop_front();
            check("bus_we", 64'(dmem_we), 64'(cur[68]));
            check("bus_addr", 64'(dmem_addr), 64'(cur[67:36]));
            check("bus_be", 64'(dmem_be), 64'(cur[35:32]));
            if (cur[68]) check("bus_wdata", 64'(dmem_wdata), 64'(cur[31:0]));
          end
        end
        if (!resp_noack && wait_cnt == resp_lat) begin
          check("bus_addr_stable", 64'(dmem_addr), 64'(cur[67:36]));
          check("bus_be_stable", 64'(dmem_be), 64'(cur[35:32]));
          dmem_ack   = 1'b1;
          dmem_err   = resp_err;
          dmem_rdata = resp_rdata;
          in_req     = 0;
        end
        wait_cnt++;
      end else begin
        if (in_req && exp_req_cycles != 0)
          check("timeout_req_cycles", 64'(wait_cnt), 64'(exp_req_cycles));
        in_req = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called and returning at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic send_op(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic mw, input logic [2:0] f3,
                         output int waits);
    bit ok;
    ok = 0;
    waits = 0;
    ex_valid = 1'b1; ex_alu_result = alu; ex_store_data = sd; ex_rd = rd;
    ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw; ex_funct3 = f3;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ex_ready) begin
        @(posedge clk); #1;
        ok = 1;
        break;
      end
      @(posedge clk); #1;
      waits++;
    end
    if (!ok) fail_now("ex_ready_timeout");
  endtask

  task automatic go_idle();
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && bus_q.size() == 0) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) fail_now({"drain_timeout_", name});
    @(posedge clk); #1;
  endtask

  // Memory op helper: queues bus and writeback expectations, then issues.
  task automatic mem_op(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                        input logic mr, input logic mw, input logic [2:0] f3,
                        input logic [31:0] rdata, input int lat,
                        input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_wdata,
                        input logic [41:0] e_wb, input string name);
    int w;
    resp_rdata = rdata;
    resp_lat   = lat;
    bus_q.push_back({mw & ~mr, e_addr, e_be, e_wdata});
    exp_q.push_back(e_wb);
    send_op(alu, sd, rd, 1'b1, mr, mw, f3, w);
    go_idle();
    drain(name);
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int w;
    reset_n = 1'b0;
    wb_ready = 1'b1;
    ex_alu_result = 32'h0; ex_store_data = 32'h0; ex_rd = 5'd0;
    ex_reg_write = 1'b0; ex_funct3 = 3'b000;
    go_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dmem_req", 64'(dmem_req), 64'(0));
    check("rst_wb_valid", 64'(wb_valid), 64'(0));
    check("rst_dmem_be", 64'(dmem_be), 64'(0));
    check("rst_dmem_addr", 64'(dmem_addr), 64'(0));
    check("rst_wb_data", 64'(wb_data), 64'(0));
    check("rst_wb_cause", 64'(wb_exc_cause), 64'(0));
    check("rst_ex_ready", 64'(ex_ready), 64'(1));
    check("rst_state", 64'(dbg_state), 64'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Non-memory op: result one cycle after accept.
    exp_q.push_back(mk_wb(1, 0, 2'b00, 1, 5'd5, 32'h0000_1234));
    send_op(32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'b010, w);
    go_idle();
    @(negedge clk);
    check("nonmem_latency_valid", 64'(wb_valid), 64'(1));
    @(posedge clk); #1;
    drain("nonmem");

    // LB / LBU lane 3
    mem_op(32'h103, 32'h0, 5'd6, 1, 0, 3'b000, 32'h80FF_0000, 1,
           32'h100, 4'b1000, 32'h0, mk_wb(1, 0, 2'b00, 1, 5'd6, 32'hFFFF_FF80), "lb");
    mem_op(32'h103, 32'h0, 5'd6, 1, 0, 3'b100, 32'h80FF_0000, 0,
           32'h100, 4'b1000, 32'h0, mk_wb(1, 0, 2'b00, 1, 5'd6, 32'h0000_0080), "lbu");
    // SH lane 2
    mem_op(32'h202, 32'h0000_ABCD, 5'd7, 0, 1, 3'b001, 32'h0, 0,
           32'h200, 4'b1100, 32'hABCD_ABCD, mk_wb(0, 0, 2'b00, 0, 5'd7, 32'h0), "sh");
    // LH / LHU lane 2
    mem_op(32'h6, 32'h0, 5'd11, 1, 0, 3'b001, 32'h8001_0000, 2,
           32'h4, 4'b1100, 32'h0, mk_wb(1, 0, 2'b00, 1, 5'd11, 32'hFFFF_8001), "lh");
    mem_op(32'h6, 32'h0, 5'd11, 1, 0, 3'b101, 32'h8001_0000, 0,
           32'h4, 4'b1100, 32'h0, mk_wb(1, 0, 2'b00, 1, 5'd11, 32'h0000_8001), "lhu");
    // SB lane 1, SW with a slow ack
    mem_op(32'h1, 32'h1234_565A, 5'd12, 0, 1, 3'b000, 32'h0, 1,
           32'h0, 4'b0010, 32'h5A5A_5A5A, mk_wb(0, 0, 2'b00, 0, 5'd12, 32'h0), "sb");
    mem_op(32'h10, 32'hDEAD_BEEF, 5'd13, 0, 1, 3'b010, 32'h0, 3,
           32'h10, 4'b1111, 32'hDEAD_BEEF, mk_wb(0, 0, 2'b00, 0, 5'd13, 32'h0), "sw");
    // LW to x0: data delivered, write enable suppressed
    mem_op(32'h20, 32'h0, 5'd0, 1, 0, 3'b010, 32'hCAFE_F00D, 2,
           32'h20, 4'b1111, 32'h0, mk_wb(1, 0, 2'b00, 0, 5'd0, 32'hCAFE_F00D), "lw_x0");
    // read+write together behaves as LB (lane 3)
    mem_op(32'h13, 32'hFFFF_FFFF, 5'd14, 1, 1, 3'b000, 32'h7F00_0000, 0,
           32'h10, 4'b1000, 32'h0, mk_wb(1, 0, 2'b00, 1, 5'd14, 32'h0000_007F), "rd_wr_as_load");

    // Misaligned LW: no bus access
    exp_q.push_back(mk_wb(0, 1, 2'b01, 0, 5'd8, 32'h0));
    send_op(32'h101, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 3'b010, w);
    go_idle();
    drain("misaligned");

    // LH with bus error
    resp_err = 1'b1;
    mem_op(32'h2, 32'h0, 5'd9, 1, 0, 3'b001, 32'h0, 1,
           32'h0, 4'b1100, 32'h0, mk_wb(0, 1, 2'b10, 0, 5'd9, 32'h0), "bus_err");
    resp_err = 1'b0;

    // Back-to-back non-memory ops, one per cycle
    exp_q.push_back(mk_wb(1, 0, 2'b00, 1, 5'd1, 32'h1111_0001));
    exp_q.push_back(mk_wb(1, 0, 2'b00, 1, 5'd2, 32'h2222_0002));
    exp_q.push_back(mk_wb(1, 0, 2'b00, 0, 5'd3, 32'h3333_0003));
    send_op(32'h1111_0001, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 3'b000, w);
    check("b2b_wait_0", 64'(w), 64'(0));
    send_op(32'h2222_0002, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 3'b000, w);
    check("b2b_wait_1", 64'(w), 64'(0));
    send_op(32'h3333_0003, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 3'b000, w);
    check("b2b_wait_2", 64'(w), 64'(0));
    go_idle();
    drain("b2b");

    // Timeout with writeback stalled, then held for 3 cycles
    wb_ready = 1'b0;
    resp_noack = 1'b1;
    exp_req_cycles = 64;
    bus_q.push_back({1'b0, 32'h40, 4'b1111, 32'h0});
    exp_q.push_back(mk_wb(0, 1, 2'b11, 0, 5'd10, 32'h0));
    send_op(32'h40, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 3'b010, w);
    go_idle();
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (wb_valid) begin
          seen = 1;
          break;
        end
      end
      if (!seen) fail_now("timeout_no_result");
    end
    @(posedge clk); #1;
    repeat (3) begin
      @(negedge clk);
      check("hold_ex_ready", 64'(ex_ready), 64'(0));
      @(posedge clk); #1;
    end
    check("hold_wb_valid", 64'(wb_valid), 64'(1));
    wb_ready = 1'b1;
    drain("timeout");
    resp_noack = 1'b0;
    exp_req_cycles = 0;

    // Reset while the bus access is outstanding
    resp_noack = 1'b1;
    bus_q.push_back({1'b0, 32'h80, 4'b1111, 32'h0});
    send_op(32'h80, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 3'b010, w);
    go_idle();
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("pre_rst_req", 64'(dmem_req), 64'(1));
    reset_n = 1'b0;
    #1;
    check("midrst_dmem_req", 64'(dmem_req), 64'(0));
    check("midrst_wb_valid", 64'(wb_valid), 64'(0));
    check("midrst_state", 64'(dbg_state), 64'(0));
    exp_q.delete();
    bus_q.delete();
    resp_noack = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(mk_wb(1, 0, 2'b00, 1, 5'd3, 32'h0000_A5A5));
    send_op(32'h0000_A5A5, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000, w);
    go_idle();
    drain("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
